// File: rtl/traffic_controller.sv
// traffic_controller
//
// Two-way intersection controller driven by the 1 Hz divider output. Main
// street rests on green; the side street is served only after a car or a
// pedestrian has asked for it. Each phase counts whole seconds, derived from
// rising edges of the divider's square wave.
//
// Ports:
//   clk              system clock (same clock as the divider)
//   controller_reset synchronous, active-high reset
//   Hz1_enable       1 Hz square wave from the divider (level, not a pulse)
//   car_sensor       side-street vehicle present (level)
//   ped_button       pedestrian crossing request (any length)
//   main_light       main-street lamps {red, yellow, green}, one-hot
//   side_light       side-street lamps {red, yellow, green}, one-hot
//   walk             pedestrian walk lamp
//   phase            current state encoding, for debug / top level
module traffic_controller #(
    parameter int unsigned MAIN_GREEN_MIN  = 10,
    parameter int unsigned YELLOW_TIME     = 3,
    parameter int unsigned ALL_RED_TIME    = 1,
    parameter int unsigned SIDE_GREEN_TIME = 8
) (
    input  logic       clk,
    input  logic       controller_reset,
    input  logic       Hz1_enable,
    input  logic       car_sensor,
    input  logic       ped_button,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;

    // Last second count of each phase; the phase ends on the tick seen with
    // this count.
    localparam logic [7:0] MAIN_GREEN_LAST = 8'(MAIN_GREEN_MIN - 1);
    localparam logic [7:0] YELLOW_LAST     = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] ALL_RED_LAST    = 8'(ALL_RED_TIME - 1);
    localparam logic [7:0] SIDE_GREEN_LAST = 8'(SIDE_GREEN_TIME - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t     state_q, state_d;
    logic [7:0] sec_count_q, sec_count_d;
    logic       side_req_q, side_req_d;
    logic       ped_req_q, ped_req_d;
    logic       walk_active_q, walk_active_d;
    logic       hz_prev_q;

    logic       tick;
    logic       illegal_state;
    logic       enter_side_green;
    logic       leave_side_green;
    logic [7:0] last_sec;
    state_t     next_timed;

    // hz_prev resets to 1 so a divider that is already high at reset
    // release does not produce a spurious tick.
    assign tick          = Hz1_enable & ~hz_prev_q;
    assign illegal_state = (state_q > ALL_RED_B);

    always_ff @(posedge clk) begin
        if (controller_reset) begin
            state_q       <= MAIN_GREEN;
            sec_count_q   <= 8'd0;
            side_req_q    <= 1'b0;
            ped_req_q     <= 1'b0;
            walk_active_q <= 1'b0;
            hz_prev_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            sec_count_q   <= sec_count_d;
            side_req_q    <= side_req_d;
            ped_req_q     <= ped_req_d;
            walk_active_q <= walk_active_d;
            hz_prev_q     <= Hz1_enable;
        end
    end

    // Next state and second counter. Timed phases share one compare against
    // their last count; main green instead waits for a latched request and
    // holds its counter at 255 while idle. Illegal encodings recover to the
    // all-red clearance immediately without waiting for a tick.
    always_comb begin
        state_d     = state_q;
        sec_count_d = sec_count_q;
        last_sec    = 8'd0;
        next_timed  = ALL_RED_B;

        case (state_q)
            MAIN_YELLOW: begin
                last_sec   = YELLOW_LAST;
                next_timed = ALL_RED_A;
            end
            ALL_RED_A: begin
                last_sec   = ALL_RED_LAST;
                next_timed = SIDE_GREEN;
            end
            SIDE_GREEN: begin
                last_sec   = SIDE_GREEN_LAST;
                next_timed = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                last_sec   = YELLOW_LAST;
                next_timed = ALL_RED_B;
            end
            ALL_RED_B: begin
                last_sec   = ALL_RED_LAST;
                next_timed = MAIN_GREEN;
            end
            default: ;
        endcase

        if (illegal_state) begin
            state_d     = ALL_RED_B;
            sec_count_d = 8'd0;
        end else if (tick) begin
            if (state_q == MAIN_GREEN) begin
                if ((sec_count_q >= MAIN_GREEN_LAST) && side_req_q) begin
                    state_d     = MAIN_YELLOW;
                    sec_count_d = 8'd0;
                end else if (sec_count_q != 8'hFF) begin
                    sec_count_d = sec_count_q + 8'd1;
                end
            end else if (sec_count_q == last_sec) begin
                state_d     = next_timed;
                sec_count_d = 8'd0;
            end else begin
                sec_count_d = sec_count_q + 8'd1;
            end
        end
    end

    // Request latches and walk enable. Entering side green serves whatever
    // is pending, so a clear wins over a same-cycle set. The walk lamp is
    // armed from the pending pedestrian request at that same moment.
    always_comb begin
        enter_side_green = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);
        leave_side_green = (state_q == SIDE_GREEN) && (state_d != SIDE_GREEN);

        side_req_d    = side_req_q | car_sensor | ped_button;
        ped_req_d     = ped_req_q | ped_button;
        walk_active_d = walk_active_q;

        if (enter_side_green) begin
            side_req_d    = 1'b0;
            ped_req_d     = 1'b0;
            walk_active_d = ped_req_q;
        end else if (leave_side_green) begin
            walk_active_d = 1'b0;
        end
    end

    // Moore lamp decode from the state register. Anything unexpected shows
    // red both ways, so the two streets can never be non-red together.
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        case (state_q)
            MAIN_GREEN:  main_light = LAMP_GREEN;
            MAIN_YELLOW: main_light = LAMP_YELLOW;
            SIDE_GREEN:  side_light = LAMP_GREEN;
            SIDE_YELLOW: side_light = LAMP_YELLOW;
            default: ;
        endcase
    end

    assign walk  = walk_active_q & (state_q == SIDE_GREEN);
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_controller.sv
// tb_traffic_controller
//
// Directed bench for traffic_controller with default timing parameters.
// Seconds are produced by toggling Hz1_enable every 4 clocks, so each call
// to applyTick delivers exactly one rising edge. Expected phases and lamp
// patterns are written out by hand for each step.
module tb_traffic_controller;

    logic       clk = 1'b0;
    logic       controller_reset;
    logic       Hz1_enable;
    logic       car_sensor;
    logic       ped_button;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;
    logic safety_on = 1'b0;

    traffic_controller dut (
        .clk              (clk),
        .controller_reset (controller_reset),
        .Hz1_enable       (Hz1_enable),
        .car_sensor       (car_sensor),
        .ped_button       (ped_button),
        .main_light       (main_light),
        .side_light       (side_light),
        .walk             (walk),
        .phase            (phase)
    );

    always #5 clk = ~clk;

    // Lamps must never both be non-red; sampled away from the active edge.
    always @(negedge clk) begin
        if (safety_on) begin
            checks++;
            assert (main_light[2] === 1'b1 || side_light[2] === 1'b1) else begin
                errors++;
                $error("[TB] FAIL safety main=%b side=%b required one red", main_light, side_light);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One second: low for 4 clocks, high for 4 clocks. The tick is registered
    // on the first edge after the rise. Optionally pulses car_sensor during
    // the very cycle in which the tick is seen.
    task automatic applyTick(input logic car_with_tick);
        Hz1_enable = 1'b0;
        step(4);
        Hz1_enable = 1'b1;
        if (car_with_tick) car_sensor = 1'b1;
        step(1);
        if (car_with_tick) car_sensor = 1'b0;
        step(3);
    endtask

    task automatic applyTicks(input int n);
        for (int i = 0; i < n; i++) applyTick(1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Phase plus its hand-listed lamp pattern and walk lamp.
    task automatic checkPhase(input string tag, input logic [2:0] exp_phase, input logic exp_walk);
        logic [2:0] exp_main;
        logic [2:0] exp_side;
        case (exp_phase)
            3'd0:    begin exp_main = 3'b001; exp_side = 3'b100; end
            3'd1:    begin exp_main = 3'b010; exp_side = 3'b100; end
            3'd3:    begin exp_main = 3'b100; exp_side = 3'b001; end
            3'd4:    begin exp_main = 3'b100; exp_side = 3'b010; end
            default: begin exp_main = 3'b100; exp_side = 3'b100; end
        endcase
        checkOutput({tag, "_phase"}, {5'd0, phase}, {5'd0, exp_phase});
        checkOutput({tag, "_main"}, {5'd0, main_light}, {5'd0, exp_main});
        checkOutput({tag, "_side"}, {5'd0, side_light}, {5'd0, exp_side});
        checkOutput({tag, "_walk"}, {7'd0, walk}, {7'd0, exp_walk});
    endtask

    task automatic pulseReset();
        controller_reset = 1'b1;
        step(1);
        controller_reset = 1'b0;
    endtask

    logic [2:0] seq_phase [5];
    int         seq_dwell [5];

    initial begin
        seq_phase = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        seq_dwell = '{3, 1, 8, 3, 1};

        controller_reset = 1'b1;
        Hz1_enable       = 1'b1;
        car_sensor       = 1'b0;
        ped_button       = 1'b0;
        step(2);
        controller_reset = 1'b0;
        safety_on        = 1'b1;

        // Reset state with the divider already high
        checkPhase("reset", 3'd0, 1'b0);
        checkOutput("reset_sec", dut.sec_count_q, 8'd0);
        checkOutput("reset_side_req", {7'd0, dut.side_req_q}, 8'd0);

        // Divider held high gives no tick
        step(100);
        checkPhase("hold_high", 3'd0, 1'b0);
        checkOutput("hold_high_sec", dut.sec_count_q, 8'd0);

        // Idle ticks keep main green; counter saturates at 255
        applyTicks(40);
        checkPhase("idle40", 3'd0, 1'b0);
        checkOutput("idle40_sec", dut.sec_count_q, 8'd40);
        applyTicks(215);
        checkOutput("idle255_sec", dut.sec_count_q, 8'd255);
        applyTicks(45);
        checkOutput("idle300_sec", dut.sec_count_q, 8'd255);
        checkPhase("idle300", 3'd0, 1'b0);

        // Car pulse after tick 2; main yellow on tick 10
        pulseReset();
        checkOutput("rst2_sec", dut.sec_count_q, 8'd0);
        applyTicks(2);
        car_sensor = 1'b1;
        step(1);
        car_sensor = 1'b0;
        checkOutput("car_latched", {7'd0, dut.side_req_q}, 8'd1);
        applyTicks(7);
        checkPhase("car_tick9", 3'd0, 1'b0);
        checkOutput("car_tick9_sec", dut.sec_count_q, 8'd9);
        applyTick(1'b0);
        checkPhase("car_tick10", 3'd1, 1'b0);
        checkOutput("car_tick10_sec", dut.sec_count_q, 8'd0);

        // Full side cycle without pedestrian: walk stays dark
        for (int p = 0; p < 5; p++) begin
            for (int i = 1; i <= seq_dwell[p]; i++) begin
                applyTick(1'b0);
                if (i == seq_dwell[p])
                    checkPhase("car_seq", (p == 4) ? 3'd0 : seq_phase[p+1], 1'b0);
                else
                    checkPhase("car_seq", seq_phase[p], 1'b0);
            end
            if (seq_phase[p] == 3'd2)
                checkOutput("car_req_cleared", {7'd0, dut.side_req_q}, 8'd0);
        end

        // Pedestrian pulse after tick 12 of main green
        applyTicks(12);
        checkPhase("ped_tick12", 3'd0, 1'b0);
        ped_button = 1'b1;
        step(1);
        ped_button = 1'b0;
        checkOutput("ped_latched", {7'd0, dut.ped_req_q}, 8'd1);
        applyTick(1'b0);
        checkPhase("ped_yellow", 3'd1, 1'b0);
        applyTicks(3);
        checkPhase("ped_allred", 3'd2, 1'b0);
        applyTick(1'b0);
        checkPhase("ped_walk_on", 3'd3, 1'b1);

        // Walk lit for all 8 side-green seconds; car arrives mid-green and holds
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) car_sensor = 1'b1;
            applyTick(1'b0);
            if (i == 8)
                checkPhase("ped_walk_off", 3'd4, 1'b0);
            else
                checkPhase("ped_walk", 3'd3, 1'b1);
        end
        applyTicks(3);
        checkPhase("held_allred_b", 3'd5, 1'b0);
        applyTick(1'b0);
        checkPhase("held_main", 3'd0, 1'b0);
        checkOutput("held_req", {7'd0, dut.side_req_q}, 8'd1);

        // Held car: main green lasts exactly 10 seconds
        for (int i = 1; i <= 10; i++) begin
            applyTick(1'b0);
            checkPhase("held_min_green", (i == 10) ? 3'd1 : 3'd0, 1'b0);
        end
        car_sensor = 1'b0;
        applyTicks(4);
        checkPhase("car_only_sg", 3'd3, 1'b0);
        applyTicks(8);
        checkPhase("mid_side_yellow0", 3'd4, 1'b0);
        applyTick(1'b0);
        checkPhase("mid_side_yellow1", 3'd4, 1'b0);

        // Reset mid side-yellow
        car_sensor = 1'b1;
        step(1);
        car_sensor = 1'b0;
        pulseReset();
        checkPhase("midreset", 3'd0, 1'b0);
        checkOutput("midreset_side_req", {7'd0, dut.side_req_q}, 8'd0);
        checkOutput("midreset_sec", dut.sec_count_q, 8'd0);

        // Request in the same cycle as a tick cannot end main green
        applyTicks(10);
        checkPhase("coinc_before", 3'd0, 1'b0);
        applyTick(1'b1);
        checkPhase("coinc_tick", 3'd0, 1'b0);
        checkOutput("coinc_req", {7'd0, dut.side_req_q}, 8'd1);
        applyTick(1'b0);
        checkPhase("coinc_served", 3'd1, 1'b0);

        // Divider frozen high: controller freezes in main yellow
        step(50);
        checkPhase("frozen", 3'd1, 1'b0);
        checkOutput("frozen_sec", dut.sec_count_q, 8'd0);

        safety_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
